// File: rtl/ram_noc_pkg.sv
// Purpose: shared request/response packet types and pack/unpack helpers for the RAM NoC node.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ram_noc_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_ADDR_WIDTH   = 4;
  localparam int DEF_N            = 16;
  localparam int DEF_N_ADDR_WIDTH = $clog2(DEF_N);
  localparam int REQ_W            = DEF_WIDTH + DEF_ADDR_WIDTH + DEF_N_ADDR_WIDTH + 2;
  localparam int RESP_W           = DEF_WIDTH + DEF_N_ADDR_WIDTH;

  // Field order is the wire order, MSB first.
  typedef struct packed {
    logic [DEF_WIDTH-1:0]        data;
    logic [DEF_ADDR_WIDTH-1:0]   addr;
    logic                        write_en;
    logic                        read_en;
    logic [DEF_N_ADDR_WIDTH-1:0] src;
  } req_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0]        data;
    logic [DEF_N_ADDR_WIDTH-1:0] node;
  } resp_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_kind_e;

  function automatic logic [REQ_W-1:0] pack_req(input req_t r);
    return r;
  endfunction

  function automatic req_t unpack_req(input logic [REQ_W-1:0] v);
    return v;
  endfunction

  function automatic logic [RESP_W-1:0] pack_resp(input resp_t r);
    return r;
  endfunction

  function automatic resp_t unpack_resp(input logic [RESP_W-1:0] v);
    return v;
  endfunction

  // Write wins when both enables are set; neither set is a malformed request.
  function automatic req_kind_e decode_kind(input logic write_en, input logic read_en);
    if (write_en)     return REQ_WRITE;
    else if (read_en) return REQ_READ;
    else              return REQ_NONE;
  endfunction

endpackage

// File: rtl/ram_resp_fifo.sv
// Purpose: first-word-fall-through sync FIFO holding read responses plus destination.
// Latency: push visible at head on the cycle after the push edge.
// Backpressure: none internally; the caller's credit scheme guarantees no push when full.
module ram_resp_fifo #(
  parameter int  W     = 16,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_do;

  assign empty  = (count == '0);
  assign pop_do = pop && !empty;
  assign head   = mem[rd_ptr];

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-2 depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (pop_do) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop_do})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A push into a full FIFO would mean the read credits were miscounted.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && count == CW'(DEPTH)));
  end

endmodule

// File: rtl/ram_req_scheduler.sv
// Purpose: accepts NoC read/write requests, issues one RAM access per cycle in order, returns read data.
// Latency: RAM strobes one cycle after accept; response valid RAM_LAT+2 cycles after a read accept.
// Backpressure: i_ready_out drops when inflight reads plus queued responses fill the response FIFO.
module ram_req_scheduler
  import ram_noc_pkg::*;
#(
  parameter int  WIDTH        = DEF_WIDTH,
  parameter int  ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int  N            = DEF_N,
  parameter int  N_ADDR_WIDTH = $clog2(N),
  parameter int  NODE         = 0,
  parameter int  RAM_LAT      = 1,
  parameter int  RESP_DEPTH   = 4,
  localparam int PACKED_REQ   = WIDTH + ADDR_WIDTH + N_ADDR_WIDTH + 2,
  localparam int PACKED_RESP  = WIDTH + N_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKED_REQ-1:0]   i_packed_in,
  input  logic                    i_valid_in,
  output logic                    i_ready_out,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [WIDTH-1:0]        ram_wdata,
  output logic                    ram_we,
  output logic                    ram_re,
  input  logic [WIDTH-1:0]        ram_rdata,
  output logic [PACKED_RESP-1:0]  o_packed_out,
  output logic [N_ADDR_WIDTH-1:0] o_dest_out,
  output logic                    o_valid_out,
  input  logic                    o_ready_in,
  output logic [7:0]              o_err_count
);

  localparam int CW       = $clog2(RESP_DEPTH + 1);
  localparam int UW       = CW + 1;
  localparam int FW       = PACKED_RESP + N_ADDR_WIDTH;
  localparam int RE_BIT   = N_ADDR_WIDTH;
  localparam int WE_BIT   = N_ADDR_WIDTH + 1;
  localparam int ADDR_LSB = N_ADDR_WIDTH + 2;
  localparam int DATA_LSB = ADDR_LSB + ADDR_WIDTH;

  // Request fields, sliced with the module's own widths.
  logic [WIDTH-1:0]        req_data;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [N_ADDR_WIDTH-1:0] req_src;
  req_kind_e               req_kind;

  assign req_data = i_packed_in[DATA_LSB +: WIDTH];
  assign req_addr = i_packed_in[ADDR_LSB +: ADDR_WIDTH];
  assign req_src  = i_packed_in[N_ADDR_WIDTH-1:0];
  assign req_kind = decode_kind(i_packed_in[WE_BIT], i_packed_in[RE_BIT]);

  logic                    started;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           fifo_count;
  logic [UW-1:0]           credit_used;
  logic                    accept;
  logic                    acc_rd;
  logic                    acc_bad;
  logic [N_ADDR_WIDTH-1:0] ram_src;
  logic [RAM_LAT-1:0]      tag_vld;
  logic [N_ADDR_WIDTH-1:0] tag_src [RAM_LAT];
  logic                    push;
  logic [FW-1:0]           push_data;
  logic                    pop;
  logic [FW-1:0]           fifo_head;
  logic                    fifo_empty;

  // Ready depends only on registered state, so senders can never influence it combinationally.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign i_ready_out = started && (credit_used < UW'(RESP_DEPTH));
  assign accept      = i_valid_in && i_ready_out;
  assign acc_rd      = accept && (req_kind == REQ_READ);
  assign acc_bad     = accept && (req_kind == REQ_NONE);

  // Holds ready low for the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst) started <= 1'b0;
    else     started <= 1'b1;
  end

  // Register the RAM access for one cycle; malformed requests produce no strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_src   <= '0;
    end else begin
      ram_we <= accept && (req_kind == REQ_WRITE);
      ram_re <= acc_rd;
      if (accept) begin
        ram_addr  <= req_addr;
        ram_wdata <= req_data;
        ram_src   <= req_src;
      end
    end
  end

  // Source tag travels alongside the read so it emerges with ram_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i < RAM_LAT; i++) tag_src[i] <= '0;
    end else begin
      tag_vld[0] <= ram_re;
      tag_src[0] <= ram_src;
      for (int i = 1; i < RAM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_src[i] <= tag_src[i-1];
      end
    end
  end

  assign push      = tag_vld[RAM_LAT-1];
  assign push_data = {ram_rdata, N_ADDR_WIDTH'(NODE), tag_src[RAM_LAT-1]};
  assign pop       = o_valid_out && o_ready_in;

  // A read holds a credit from accept until its data lands in the FIFO.
  always_ff @(posedge clk) begin
    if (rst) inflight <= '0;
    else     inflight <= inflight + CW'(acc_rd) - CW'(push);
  end

  // Malformed-request counter, saturating.
  always_ff @(posedge clk) begin
    if (rst)                             o_err_count <= '0;
    else if (acc_bad && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
  end

  ram_resp_fifo #(
    .W     (FW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs read zero when nothing is queued so stale storage never leaks out.
  assign o_valid_out  = !fifo_empty;
  assign o_packed_out = o_valid_out ? fifo_head[FW-1:N_ADDR_WIDTH] : '0;
  assign o_dest_out   = o_valid_out ? fifo_head[N_ADDR_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_ram_req_scheduler.sv
// Purpose: directed and random checks of ram_req_scheduler against a queue-based reference model.
// Latency: n/a.
// Backpressure: exercises o_ready_in stalls and credit exhaustion.
module tb_ram_req_scheduler;
  import ram_noc_pkg::*;

  localparam int NODE_ID = 3;
  localparam int RAM_LAT = 1;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] i_packed_in = '0;
  logic        i_valid_in = 1'b0;
  logic        i_ready_out;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [7:0]  ram_rdata = '0;
  logic [11:0] o_packed_out;
  logic [3:0]  o_dest_out;
  logic        o_valid_out;
  logic        o_ready_in = 1'b0;
  logic [7:0]  o_err_count;

  ram_req_scheduler #(
    .NODE       (NODE_ID),
    .RAM_LAT    (RAM_LAT),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_packed_in  (i_packed_in),
    .i_valid_in   (i_valid_in),
    .i_ready_out  (i_ready_out),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_re       (ram_re),
    .ram_rdata    (ram_rdata),
    .o_packed_out (o_packed_out),
    .o_dest_out   (o_dest_out),
    .o_valid_out  (o_valid_out),
    .o_ready_in   (o_ready_in),
    .o_err_count  (o_err_count)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous read, one cycle of latency.
  logic [7:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= ram_mem[ram_addr];
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
  end

  // Reference model: memory contents, ordered expected responses {data, dest}, error count.
  logic [7:0]  model_mem [16];
  logic [11:0] exp_q [$];
  int          err_exp = 0;
  int          errors = 0;
  int          checks = 0;
  int          pops = 0;
  bit          last_acc = 1'b0;
  bit          toggle_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the response handshake and update the model on an accepted request.
  task automatic cyc();
    logic [11:0] e;
    req_t        r;
    if (toggle_rdy) o_ready_in = ~o_ready_in;
    last_acc = 1'b0;
    if (!rst) begin
      if (o_valid_out) begin
        if (exp_q.size() == 0) chk("spurious_valid", 32'(o_valid_out), 32'd0);
        else if (o_ready_in) begin
          e = exp_q.pop_front();
          chk("resp_data", 32'(o_packed_out), 32'({e[11:4], 4'(NODE_ID)}));
          chk("resp_dest", 32'(o_dest_out), 32'(e[3:0]));
          pops++;
        end
      end
      if (i_valid_in && i_ready_out) begin
        last_acc = 1'b1;
        r = unpack_req(i_packed_in);
        if (r.write_en)     model_mem[r.addr] = r.data;
        else if (r.read_en) exp_q.push_back({model_mem[r.addr], r.src});
        else if (err_exp < 255) err_exp++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic re, input logic [3:0] addr,
                      input logic [7:0] dat, input logic [3:0] src);
    req_t r;
    r.data = dat; r.addr = addr; r.write_en = we; r.read_en = re; r.src = src;
    i_packed_in = pack_req(r);
    i_valid_in  = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (last_acc) break;
    end
    if (!last_acc) chk("accept_timeout", 32'(last_acc), 32'd1);
    i_valid_in = 1'b0;
  endtask

  task automatic drain(input int max);
    toggle_rdy = 1'b0;
    o_ready_in = 1'b1;
    for (int k = 0; k < max; k++) begin
      if (exp_q.size() == 0 && !o_valid_out) break;
      cyc();
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    i_valid_in = 1'b0;
    exp_q.delete();
    err_exp = 0;
    repeat (n) cyc();
    chk("rst_ram", {12'd0, ram_we, ram_re, ram_addr, ram_wdata, i_ready_out, o_valid_out, 4'd0},
        32'd0);
    chk("rst_out", {8'd0, o_packed_out, o_dest_out, o_err_count}, 32'd0);
    rst = 1'b0;
    chk("ready_first_cycle", 32'(i_ready_out), 32'd0);
    cyc();
    chk("ready_after", 32'(i_ready_out), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i]   = 8'(i * 17 + 3);
      model_mem[i] = 8'(i * 17 + 3);
    end
    do_reset(3);

    // 1: write then read-back, with read latency measured from the accept edge.
    o_ready_in = 1'b1;
    send(1'b1, 1'b0, 4'd3, 8'h5A, 4'd2);
    chk("t1_wr_strobe", {22'd0, ram_we, ram_re, ram_addr, 4'd0}, {22'd0, 2'b10, 4'd3, 4'd0});
    chk("t1_wdata", 32'(ram_wdata), 32'h5A);
    p0 = pops;
    send(1'b0, 1'b1, 4'd3, 8'h00, 4'd2);
    chk("t1_rd_strobe", {30'd0, ram_we, ram_re}, 32'd1);
    n = 1;
    while (!o_valid_out && n < 20) begin
      cyc();
      n++;
    end
    chk("t1_latency", 32'(n), 32'(RAM_LAT + 2));
    drain(20);
    chk("t1_one_resp", 32'(pops - p0), 32'd1);

    // 2: credit exhaustion with the NoC stalled, then release.
    o_ready_in = 1'b0;
    for (int k = 0; k < 4; k++) send(1'b0, 1'b1, 4'(k), 8'h00, 4'(k + 4));
    chk("t2_credit_full", 32'(i_ready_out), 32'd0);
    repeat (3) cyc();
    chk("t2_credit_hold", 32'(i_ready_out), 32'd0);
    chk("t2_head_stable", 32'(o_dest_out), 32'(exp_q[0][3:0]));
    o_ready_in = 1'b1;
    p0 = pops;
    send(1'b0, 1'b1, 4'd9, 8'h00, 4'd9);
    drain(40);
    chk("t2_five_resp", 32'(pops - p0), 32'd5);

    // 3: malformed request.
    chk("t3_err_before", 32'(o_err_count), 32'(err_exp));
    send(1'b0, 1'b0, 4'd7, 8'hEE, 4'd1);
    chk("t3_no_strobe", {30'd0, ram_we, ram_re}, 32'd0);
    chk("t3_err_after", 32'(o_err_count), 32'(err_exp));
    chk("t3_ready", 32'(i_ready_out), 32'd1);

    // 4: both enables -> write only; then read it back.
    send(1'b1, 1'b1, 4'd5, 8'h11, 4'd6);
    chk("t4_we_only", {30'd0, ram_we, ram_re}, 32'd2);
    repeat (5) cyc();
    chk("t4_no_resp", 32'(o_valid_out), 32'd0);
    send(1'b0, 1'b1, 4'd5, 8'h00, 4'd6);
    drain(20);

    // 5: eight back-to-back reads with the NoC ready toggling.
    o_ready_in = 1'b1;
    toggle_rdy = 1'b1;
    p0 = pops;
    for (int k = 1; k <= 8; k++) send(1'b0, 1'b1, 4'($urandom_range(0, 15)), 8'h00, 4'(k));
    drain(60);
    chk("t5_eight_resp", 32'(pops - p0), 32'd8);

    // 6: reset with two reads queued and two in flight.
    o_ready_in = 1'b0;
    send(1'b0, 1'b1, 4'd1, 8'h00, 4'd1);
    send(1'b0, 1'b1, 4'd2, 8'h00, 4'd2);
    repeat (4) cyc();
    send(1'b0, 1'b1, 4'd3, 8'h00, 4'd3);
    send(1'b0, 1'b1, 4'd4, 8'h00, 4'd4);
    do_reset(2);
    o_ready_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t6_quiet", 32'(o_valid_out), 32'd0);
      cyc();
    end
    send(1'b0, 1'b1, 4'd8, 8'h00, 4'd12);
    drain(20);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      o_ready_in  = ($urandom_range(0, 3) != 0);
      i_valid_in  = ($urandom_range(0, 9) < 7);
      i_packed_in = 18'($urandom);
      cyc();
    end
    i_valid_in = 1'b0;
    drain(100);
    chk("rand_err_count", 32'(o_err_count), 32'(err_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
